// File: rtl/ocmkai_control_device.sv
// OCM-kai switched-I/O control device (ports 0x40-0x42): device select, index and data registers.
// Optional build macro OCMKAI_CTRL_AUTOINC_EN: index post-increments after each selected 0x42 access.
module ocmkai_control_device #(
  parameter logic [7:0] DEVICE_ID       = 8'd213,
  parameter logic [7:0] VERSION         = 8'h01,
  parameter logic [4:0] ESERAM_ID_RESET = 5'd0
) (
  input  logic       clk21m,
  input  logic       reset_n,
  input  logic       req,
  output logic       ack,
  input  logic       wrt,
  input  logic [7:0] adr,
  output logic [7:0] dbi,
  input  logic [7:0] dbo,
  output logic [4:0] eseram_memory_id
);

  // Bus handshake: req is held high for a whole access; the access is
  // performed once on the rising edge of req, and ack is req delayed by one clock.
  logic       req_q, req_d;
  logic       ack_q, ack_d;
  logic [7:0] dbi_q, dbi_d;
  logic [7:0] sel_id_q, sel_id_d;
  logic [7:0] index_q, index_d;
  logic [7:0] reg1_q, reg1_d;
  logic [4:0] eid_q, eid_d;

  logic       access_edge;
  logic       selected;
  logic [7:0] reg_rdata;
  logic [7:0] rdata;

  always_comb begin
    access_edge = req & ~req_q;
    selected    = (sel_id_q == DEVICE_ID);

    case (index_q)
      8'd0:    reg_rdata = VERSION;
      8'd1:    reg_rdata = reg1_q;
      8'd2:    reg_rdata = {3'b000, eid_q};
      default: reg_rdata = 8'hFF;
    endcase

    case (adr)
      8'h40:   rdata = selected ? ~DEVICE_ID : 8'hFF;
      8'h41:   rdata = selected ? index_q : 8'hFF;
      8'h42:   rdata = selected ? reg_rdata : 8'hFF;
      default: rdata = 8'hFF;
    endcase
  end

  always_comb begin
    req_d    = req;
    ack_d    = req;
    dbi_d    = dbi_q;
    sel_id_d = sel_id_q;
    index_d  = index_q;
    reg1_d   = reg1_q;
    eid_d    = eid_q;

    if (access_edge) begin
      if (wrt) begin
        case (adr)
          8'h40: sel_id_d = dbo;
          8'h41: if (selected) index_d = dbo;
          8'h42: begin
            if (selected) begin
              if (index_q == 8'd1) reg1_d = dbo;
              if (index_q == 8'd2) eid_d  = dbo[4:0];
            end
          end
          default: ;
        endcase
      end else begin
        dbi_d = rdata;
      end
`ifdef OCMKAI_CTRL_AUTOINC_EN
      if (selected && (adr == 8'h42)) index_d = index_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      dbi_q    <= 8'hFF;
      sel_id_q <= 8'h00;
      index_q  <= 8'h00;
      reg1_q   <= 8'h00;
      eid_q    <= ESERAM_ID_RESET;
    end else begin
      req_q    <= req_d;
      ack_q    <= ack_d;
      dbi_q    <= dbi_d;
      sel_id_q <= sel_id_d;
      index_q  <= index_d;
      reg1_q   <= reg1_d;
      eid_q    <= eid_d;
    end
  end

  assign ack              = ack_q;
  assign dbi              = dbi_q;
  assign eseram_memory_id = eid_q;

endmodule

// Legacy spelling kept so older top levels still elaborate.
module ocmkai_control_decice #(
  parameter logic [7:0] DEVICE_ID       = 8'd213,
  parameter logic [7:0] VERSION         = 8'h01,
  parameter logic [4:0] ESERAM_ID_RESET = 5'd0
) (
  input  logic       clk21m,
  input  logic       reset_n,
  input  logic       req,
  output logic       ack,
  input  logic       wrt,
  input  logic [7:0] adr,
  output logic [7:0] dbi,
  input  logic [7:0] dbo,
  output logic [4:0] eseram_memory_id
);
  ocmkai_control_device #(
    .DEVICE_ID(DEVICE_ID), .VERSION(VERSION), .ESERAM_ID_RESET(ESERAM_ID_RESET)
  ) u_dev (
    .clk21m(clk21m), .reset_n(reset_n), .req(req), .ack(ack), .wrt(wrt),
    .adr(adr), .dbi(dbi), .dbo(dbo), .eseram_memory_id(eseram_memory_id)
  );
endmodule

// File: tb/tb_ocmkai_control_device.sv
// Bench for ocmkai_control_device: directed and random bus accesses, reference model feeds
// an expected queue that a negedge monitor drains on every ack rising edge.
module tb_ocmkai_control_device;

  localparam logic [7:0] DEV_ID  = 8'd213;
  localparam logic [7:0] VER     = 8'h01;
  localparam logic [4:0] EID_RST = 5'd0;

  logic       clk21m = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic       wrt = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] dbi;
  logic [7:0] dbo = 8'h00;
  logic [4:0] eseram_memory_id;

  int vectors = 0;
  int miscompares = 0;

  // Entry layout: {is_read, expected dbi, expected eseram_memory_id}.
  logic [13:0] exp_q[$];

  // Reference model state.
  logic [7:0] m_sel, m_idx, m_reg1;
  logic [4:0] m_eid;
  logic [7:0] m_dbi;

  ocmkai_control_device #(
    .DEVICE_ID(DEV_ID), .VERSION(VER), .ESERAM_ID_RESET(EID_RST)
  ) dut (
    .clk21m(clk21m), .reset_n(reset_n), .req(req), .ack(ack), .wrt(wrt),
    .adr(adr), .dbi(dbi), .dbo(dbo), .eseram_memory_id(eseram_memory_id)
  );

  always #5 clk21m = ~clk21m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 8'h00; m_idx = 8'h00; m_reg1 = 8'h00; m_eid = EID_RST; m_dbi = 8'hFF;
  endtask

  // Register file semantics expressed directly from the device description.
  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic on;
    on = (m_sel == DEV_ID);
    if (!on) return 8'hFF;
    if (a == 8'h40) return ~DEV_ID;
    if (a == 8'h41) return m_idx;
    if (a == 8'h42) begin
      if (m_idx == 0) return VER;
      if (m_idx == 1) return m_reg1;
      if (m_idx == 2) return {3'b000, m_eid};
    end
    return 8'hFF;
  endfunction

  task automatic model_access(input logic w, input logic [7:0] a, input logic [7:0] d);
    logic on;
    on = (m_sel == DEV_ID);
    if (w) begin
      if (a == 8'h40) m_sel = d;
      else if (on && a == 8'h41) m_idx = d;
      else if (on && a == 8'h42 && m_idx == 1) m_reg1 = d;
      else if (on && a == 8'h42 && m_idx == 2) m_eid = d % 32;
    end else begin
      m_dbi = model_read(a);
    end
`ifdef OCMKAI_CTRL_AUTOINC_EN
    if (on && a == 8'h42) m_idx = (m_idx + 1) % 256;
`endif
    exp_q.push_back({~w, m_dbi, m_eid});
  endtask

  // Called aligned at posedge+2; leaves alignment at posedge+2.
  task automatic bus_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int hold, input int gap);
    model_access(w, a, d);
    req = 1'b1; wrt = w; adr = a; dbo = d;
    repeat (hold) @(posedge clk21m);
    #2;
    req = 1'b0; wrt = 1'b0;
    repeat (gap) @(posedge clk21m);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk21m);
    #2;
  endtask

  // Monitor: ack tracks req one clock late; on ack rise pop the next expectation;
  // dbi and eseram_memory_id must hold their expected values every cycle.
  logic       mon_req_prev = 1'b0;
  logic       mon_ack_prev = 1'b0;
  logic [7:0] mon_dbi = 8'hFF;
  logic [4:0] mon_eid = EID_RST;

  always @(negedge clk21m) begin
    logic [13:0] e;
    if (!reset_n) begin
      mon_req_prev = 1'b0;
      mon_ack_prev = 1'b0;
      mon_dbi      = 8'hFF;
      mon_eid      = EID_RST;
    end else begin
      check("ack_follows_req", {7'd0, ack}, {7'd0, mon_req_prev});
      if (ack && !mon_ack_prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack: ack rose with no access pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[13]) mon_dbi = e[12:5];
          mon_eid = e[4:0];
        end
      end
      check("dbi", dbi, mon_dbi);
      check("eseram_memory_id", {3'b000, eseram_memory_id}, {3'b000, mon_eid});
      mon_ack_prev = ack;
      mon_req_prev = req;
    end
  end

  initial begin
    logic [7:0] a, d;
    logic       w;
    int         pick;
    model_reset();
    #12;
    reset_n = 1'b1;
    @(posedge clk21m); #2;

    idle(100);
    check("idle_ack", {7'd0, ack}, 8'd0);
    check("idle_dbi", dbi, 8'hFF);
    check("idle_eid", {3'b000, eseram_memory_id}, 8'd0);

    bus_access(1'b1, 8'h40, DEV_ID, 4, 1);
    bus_access(1'b0, 8'h40, 8'h00, 4, 1);
    check("read_0x40_selected", dbi, 8'h2A);

    bus_access(1'b1, 8'h41, 8'd2, 4, 1);
    bus_access(1'b1, 8'h42, 8'd123, 4, 1);
    check("eid_after_write", {3'b000, eseram_memory_id}, 8'd27);
    bus_access(1'b0, 8'h42, 8'h00, 4, 1);
    check("read_0x42_eid", dbi, 8'h1B);

    bus_access(1'b1, 8'h40, 8'h00, 2, 1);
    bus_access(1'b1, 8'h42, 8'd5, 2, 1);
    bus_access(1'b0, 8'h41, 8'h00, 2, 1);
    check("deselected_0x41", dbi, 8'hFF);
    check("deselected_eid_kept", {3'b000, eseram_memory_id}, 8'd27);

    bus_access(1'b1, 8'h40, DEV_ID, 1, 1);
    bus_access(1'b1, 8'h41, 8'd0, 1, 1);
    bus_access(1'b0, 8'h42, 8'h00, 3, 1);
    check("version", dbi, VER);
    bus_access(1'b1, 8'h41, 8'd1, 1, 2);
    bus_access(1'b1, 8'h42, 8'hA5, 3, 1);
    bus_access(1'b1, 8'h41, 8'd1, 1, 1);
    bus_access(1'b0, 8'h42, 8'h00, 3, 1);
    check("reg1_rw", dbi, 8'hA5);

    // Two consecutive data writes starting at index 1 (post-increment builds advance to 3).
    bus_access(1'b1, 8'h41, 8'd1, 1, 1);
    bus_access(1'b1, 8'h42, 8'h11, 2, 1);
    bus_access(1'b1, 8'h42, 8'h07, 2, 1);
    bus_access(1'b0, 8'h41, 8'h00, 2, 1);
`ifdef OCMKAI_CTRL_AUTOINC_EN
    check("autoinc_index", dbi, 8'd3);
    check("autoinc_eid", {3'b000, eseram_memory_id}, 8'd7);
`else
    check("fixed_index", dbi, 8'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 9);
      w = $urandom_range(0, 1);
      d = $urandom;
      if (pick < 2) begin
        a = 8'h40;
        if (w && $urandom_range(0, 3) != 0) d = DEV_ID;
      end else if (pick < 4) begin
        a = 8'h41;
        if ($urandom_range(0, 3) != 0) d = $urandom_range(0, 3);
        else if ($urandom_range(0, 1) == 1) d = 8'hFF;
      end else if (pick < 8) begin
        a = 8'h42;
      end else begin
        a = $urandom;
      end
      bus_access(w, a, d, $urandom_range(1, 4), $urandom_range(1, 3));
    end

    // Reset in the middle of a held access: outputs go to reset values at once.
    bus_access(1'b1, 8'h40, DEV_ID, 1, 1);
    bus_access(1'b1, 8'h41, 8'd2, 1, 1);
    bus_access(1'b1, 8'h42, 8'h1F, 1, 1);
    model_access(1'b0, 8'h42, 8'h00);
    req = 1'b1; wrt = 1'b0; adr = 8'h42;
    repeat (2) @(posedge clk21m);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_ack", {7'd0, ack}, 8'd0);
    check("rst_dbi", dbi, 8'hFF);
    check("rst_eid", {3'b000, eseram_memory_id}, {3'b000, EID_RST});
    req = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk21m);
    #2;
    reset_n = 1'b1;
    idle(2);
    bus_access(1'b0, 8'h41, 8'h00, 2, 1);
    check("post_reset_deselected", dbi, 8'hFF);

    idle(3);
    check("queue_drained", exp_q.size() % 256, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
